// File: rtl/ysyx_24080006_mdu_if.sv
// ysyx_24080006_mdu_if: request/response bundle between the execute stage and the MDU.
// mdu_set = {mdu_enable, signed_a, signed_b, mdu_op}; mdu_op 0=MULL 1=MULH 2=DIV 3=REM.
interface ysyx_24080006_mdu_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  mdu_set;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;
    modport master (output in_valid, mdu_set, op_a, op_b, out_ready,
                    input in_ready, out_valid, result, busy);
    modport slave (input in_valid, mdu_set, op_a, op_b, out_ready,
                   output in_ready, out_valid, result, busy);
endinterface

// File: rtl/ysyx_24080006_mdu.sv
// ysyx_24080006_mdu: iterative RV32M multiply (shift-add) / divide (restoring) unit.
// Define MDU_FAST_MUL_EN to replace the shift-add multiplier with one combinational 33x33 multiply.
module ysyx_24080006_mdu (
    input logic clock,
    input logic reset,
    input logic flush,
    ysyx_24080006_mdu_if.slave bus
);
`ifdef MDU_FAST_MUL_EN
    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`endif
    state_t state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sel_hi_q, sel_hi_d;
    logic        neg_q_q, neg_q_d;
    logic        neg_r_q, neg_r_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] result_q, result_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
`ifndef MDU_FAST_MUL_EN
    logic [32:0] mcand_q, mcand_d;
    logic [65:0] prod_q, prod_d;
    logic [33:0] madd, msum;
    logic [65:0] prod_nxt;
`else
    logic [63:0] full;
`endif
    logic        a_sign, b_sign, is_div, hi, div0, ovf, accept, ge;
    logic [32:0] a33, b33, r_sh, dsub;
    logic [31:0] abs_a, abs_b, spec_res, rem_nxt, quo_nxt, q_fin, r_fin;
    logic        unused_ok;
    assign a_sign   = bus.mdu_set[3] & bus.op_a[31];
    assign b_sign   = bus.mdu_set[2] & bus.op_b[31];
    assign a33      = {a_sign, bus.op_a};
    assign b33      = {b_sign, bus.op_b};
    assign abs_a    = a_sign ? -bus.op_a : bus.op_a;
    assign abs_b    = b_sign ? -bus.op_b : bus.op_b;
    assign is_div   = bus.mdu_set[1];
    assign hi       = bus.mdu_set[0];
    assign div0     = bus.op_b == 32'd0;
    assign ovf      = bus.mdu_set[3] & bus.mdu_set[2] & (bus.op_a == 32'h8000_0000) & (bus.op_b == 32'hFFFF_FFFF);
    assign spec_res = div0 ? (hi ? bus.op_a : 32'hFFFF_FFFF) : (hi ? 32'd0 : 32'h8000_0000);
    assign accept   = bus.in_valid && state_q == IDLE && !flush;
`ifndef MDU_FAST_MUL_EN
    // Last iteration weighs the multiplier sign bit negatively, so subtract instead of add.
    assign madd     = {mcand_q[32], mcand_q};
    assign msum     = {prod_q[65], prod_q[65:33]} + (prod_q[0] ? (cnt_q == 6'd32 ? -madd : madd) : 34'd0);
    assign prod_nxt = {msum, prod_q[32:1]};
`else
    assign full     = 64'($signed(a33)) * 64'($signed(b33));
`endif
    assign r_sh     = {rem_q, quo_q[31]};
    assign ge       = r_sh >= {1'b0, dvsr_q};
    assign dsub     = r_sh - {1'b0, dvsr_q};
    assign rem_nxt  = ge ? dsub[31:0] : r_sh[31:0];
    assign quo_nxt  = {quo_q[30:0], ge};
    assign q_fin    = neg_q_q ? -quo_nxt : quo_nxt;
    assign r_fin    = neg_r_q ? -rem_nxt : rem_nxt;
    assign unused_ok = ^{bus.mdu_set[4], dsub[32]};
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_hi_d    = sel_hi_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
`ifndef MDU_FAST_MUL_EN
        mcand_d     = mcand_q;
        prod_d      = prod_q;
`endif
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    sel_hi_d = hi;
                    cnt_d    = 6'd0;
                    neg_q_d  = a_sign ^ b_sign;
                    neg_r_d  = a_sign;
                    if (is_div) begin
                        if (div0 || ovf) begin
                            state_d     = DONE;
                            out_valid_d = 1'b1;
                            result_d    = spec_res;
                        end else begin
                            state_d = DIV;
                            rem_d   = 32'd0;
                            quo_d   = abs_a;
                            dvsr_d  = abs_b;
                        end
                    end else begin
`ifdef MDU_FAST_MUL_EN
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        result_d    = hi ? full[63:32] : full[31:0];
`else
                        state_d = MUL;
                        mcand_d = a33;
                        prod_d  = {33'd0, b33};
`endif
                    end
                end
`ifndef MDU_FAST_MUL_EN
                MUL: begin
                    prod_d = prod_nxt;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == 6'd32) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        result_d    = sel_hi_q ? prod_nxt[63:32] : prod_nxt[31:0];
                    end
                end
`endif
                DIV: begin
                    rem_d = rem_nxt;
                    quo_d = quo_nxt;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        result_d    = sel_hi_q ? r_fin : q_fin;
                    end
                end
                default: if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            sel_hi_q    <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
            rem_q       <= 32'd0;
            quo_q       <= 32'd0;
            dvsr_q      <= 32'd0;
`ifndef MDU_FAST_MUL_EN
            mcand_q     <= 33'd0;
            prod_q      <= 66'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_hi_q    <= sel_hi_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
`ifndef MDU_FAST_MUL_EN
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
`endif
        end
    end
    assign bus.in_ready  = state_q == IDLE;
    assign bus.busy      = state_q != IDLE;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
endmodule

// File: doc/ysyx_24080006_mdu.md
Name: ysyx_24080006_mdu

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, beside the ALU.
- Consumes the mdu_set_t field of decoder_t and the rs1/rs2 operands carried in stage_t. Returns a 32-bit result to the writeback mux.
- Multi-cycle with valid/ready on both sides. The pipeline stalls on in_ready/out_valid. Flushable on redirect.

Parameters:
- none; operand width is fixed at 32 (RV32M).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline redirect; aborts any operation in flight
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request
- mdu_set  in  mdu_set_t  {mdu_enable, signed_a, signed_b, mdu_op}; mdu_enable is ignored (in_valid qualifies)
- op_a  in  32  rs1 data (multiplicand / dividend)
- op_b  in  32  rs2 data (multiplier / divisor)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  32  MUL/MULH*/DIV*/REM* result
- busy  out  1  state != IDLE

Behaviour:
- Reset: clock is the single clock; reset is synchronous and active-high. On reset the state goes to IDLE, out_valid=0, result=0, busy=0, in_ready=1, and all internal registers are cleared.
- States are IDLE, MUL, DIV, DONE.
- Accept: a request is accepted when in_valid && in_ready && !flush. in_ready = (state==IDLE). Operands and controls are latched on acceptance.
- Operand extension: a33 = {signed_a & op_a[31], op_a} and b33 = {signed_b & op_b[31], op_b}.
- MUL (ALU_MULL, ALU_MULH):
  - Radix-2 shift-add on the 33-bit sign-extended operands, with a 6-bit counter running 0..32.
  - 33 iterations; the last one applies a two's-complement correction when the b33 sign bit is set.
  - The product is 66 bits, truncated to 64.
  - MULL returns prod[31:0]. MULH returns prod[63:32]; MULH/MULHSU/MULHU are selected by the signed bits.
- DIV (ALU_DIV, ALU_REM):
  - Restoring division on magnitudes; 32 iterations with a 33-bit partial remainder.
  - Quotient is negated if signed && (a_sign ^ b_sign). Remainder takes the sign of the dividend.
- Special cases: decided in the acceptance cycle; go straight to DONE with no iteration.
  - Divide by zero (op_b==0): DIV returns 32'hFFFF_FFFF; REM returns op_a.
  - Signed overflow (op_a==32'h8000_0000, op_b==32'hFFFF_FFFF, signed): DIV returns 32'h8000_0000; REM returns 0.
- Latency, with acceptance at cycle T:
  - special cases: out_valid at T+1
  - DIV: out_valid at T+33
  - MUL: out_valid at T+34
- Transitions:
  - IDLE -> MUL or DIV on acceptance; IDLE -> DONE on a special case.
  - MUL or DIV -> DONE when the counter hits its final value. The result register is loaded on the same edge.
  - DONE -> IDLE on out_ready. in_ready is 0 during DONE; there is no back-to-back bypass.
- Output hold: out_valid and result are held stable in DONE until out_ready is sampled high.
- Flush: from any state the next state is IDLE and out_valid drops to 0 next cycle. Flush and in_valid in the same cycle: the request is not accepted. Flush in DONE while out_ready=1: the handshake completes and the result is discarded by the consumer.
- Reset mid-operation: same effect as flush, plus result is cleared.
- mdu_op values outside the four encodings cannot occur; they are treated as ALU_MULL.

Optional Feature:
- Macro MDU_FAST_MUL_EN.
- Defined: multiply uses a single 33x33 signed combinational multiply registered into DONE. MUL latency is out_valid at T+1, and the MUL state and its iteration logic are removed.
- Undefined: the iterative 33-cycle shift-add described above.
- Division and all special cases are identical in both builds.

Test Plan:
- MULL 7 x -3 (signed_a=signed_b=1), accept at T -> out_valid at T+34, result=32'hFFFF_FFEB. With MDU_FAST_MUL_EN the same result appears at T+1.
- MULH/MULHSU/MULHU with op_a=op_b=32'h8000_0000 -> 32'h4000_0000 / 32'hC000_0000 / 32'h4000_0000.
- DIV -7/2 signed -> 32'hFFFF_FFFD at T+33; REM -7/2 signed -> 32'hFFFF_FFFF. DIVU 32'hFFFF_FFFF/16 -> 32'h0FFF_FFFF.
- DIV x/0 -> 32'hFFFF_FFFF at T+1; REM 123/0 -> 123. Signed DIV 32'h8000_0000/-1 -> 32'h8000_0000; REM -> 0, both at T+1.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and result stable and in_ready=0. Raise out_ready -> IDLE and in_ready=1 next cycle.
- flush at T+10 during DIV -> state IDLE at T+11 and no out_valid. flush asserted together with in_valid -> the request is dropped. reset at T+5 -> all outputs at their reset values next cycle.
